// File: rtl/mem_loader.sv
// mem_loader: fills the instruction memory from a valid/ready byte stream,
// then compares a trailing checksum byte against the running byte sum.
// busy holds the CPU off from the start of a load until the checksum result.

module mem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              ok,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [7:0]          sum_q;
    logic [7:0]          sum_d;
    logic                active_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [7:0]          wdata_q;
    logic                done_q;
    logic                ok_q;
    logic                err_q;
    logic                accept;
    logic                lastByte;

    // active_q is high exactly in LOAD and CHECK, so it serves as both
    // the stream ready and the CPU hold.
    assign accept   = in_valid & active_q;
    assign sum_d    = sum_q + in_data;
    assign lastByte = (cnt_q == ADDR_W'(DEPTH - 1));

    // Load sequencer: state, byte counter, checksum and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sum_q    <= '0;
            active_q <= 1'b0;
            mem_we_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q  <= LOAD;
                        active_q <= 1'b1;
                        cnt_q    <= '0;
                        sum_q    <= '0;
                        done_q   <= 1'b0;
                        ok_q     <= 1'b0;
                        err_q    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem_we_q <= 1'b1;
                        waddr_q  <= cnt_q;
                        wdata_q  <= in_data;
                        sum_q    <= sum_d;
                        cnt_q    <= cnt_q + 1'b1;
                        if (lastByte) begin
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        state_q  <= DONE;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                        ok_q     <= (in_data == sum_q);
                        err_q    <= (in_data != sum_q);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = active_q;
    assign busy      = active_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign ok        = ok_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: drives whole program loads with random gaps and data and
// compares the write strobes and checksum verdict against a transaction-level
// model (expected write list = bytes in order, verdict = byte sum mod 256).

module tb_mem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              ok;
    logic              err;

    int checks   = 0;
    int failures = 0;
    int edgeCnt  = 0;

    logic [7:0]        ldData [DEPTH];
    logic [ADDR_W-1:0] wrAddrQ [$];
    logic [7:0]        wrDataQ [$];
    logic [ADDR_W-1:0] lastAddr;
    logic [7:0]        lastData;

    mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .ok        (ok),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt++;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Expected checksum: plain byte sum modulo 256.
    function automatic logic [7:0] modelSum();
        int s = 0;
        for (int i = 0; i < DEPTH; i++) s += int'(ldData[i]);
        return 8'(s % 256);
    endfunction

    // Write-port monitor: records every strobe and checks that address/data
    // hold their last strobed value while the strobe is low.
    always @(negedge clk) begin
        if (rst) begin
            lastAddr = '0;
            lastData = '0;
        end else if (mem_we) begin
            wrAddrQ.push_back(mem_waddr);
            wrDataQ.push_back(mem_wdata);
            lastAddr = mem_waddr;
            lastData = mem_wdata;
        end else begin
            checkOutput("waddr_hold", 32'(mem_waddr), 32'(lastAddr));
            checkOutput("wdata_hold", 32'(mem_wdata), 32'(lastData));
        end
    end

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({pfx, "_mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({pfx, "_waddr"}, 32'(mem_waddr), 32'd0);
        checkOutput({pfx, "_wdata"}, 32'(mem_wdata), 32'd0);
        checkOutput({pfx, "_busy"}, 32'(busy), 32'd0);
        checkOutput({pfx, "_done"}, 32'(done), 32'd0);
        checkOutput({pfx, "_ok"}, 32'(ok), 32'd0);
        checkOutput({pfx, "_err"}, 32'(err), 32'd0);
    endtask

    // One complete load of ldData plus checksum cks. gapPct is the chance of
    // in_valid being low in a cycle; startAt is a byte index at which start
    // is held high mid-load (-1 for none); cksStart holds start high while
    // the checksum byte is offered.
    task automatic applyStimulus(input int gapPct, input int startAt,
                                 input bit cksStart, input logic [7:0] cks);
        int   idx      = 0;
        int   budget   = 0;
        int   sEdge;
        bit   r;
        bit   v;
        bit   lastBusy = 1'b0;
        bit   lastDone = 1'b1;
        logic [7:0] expSum = modelSum();
        bit   expOk    = (expSum == cks);

        @(negedge clk);
        #1;
        wrAddrQ.delete();
        wrDataQ.delete();
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        sEdge = edgeCnt;
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_ready", 32'(in_ready), 32'd1);
        checkOutput("start_done_clr", 32'(done), 32'd0);
        checkOutput("start_ok_clr", 32'(ok), 32'd0);
        checkOutput("start_err_clr", 32'(err), 32'd0);

        while (idx < DEPTH + 1 && budget < 3000) begin
            r        = in_ready;
            lastBusy = busy;
            lastDone = done;
            #1;
            v        = ($urandom_range(99) >= gapPct);
            in_valid = v;
            in_data  = (idx < DEPTH) ? ldData[idx] : cks;
            start    = (idx == startAt) || (idx == DEPTH && cksStart);
            if (v && r) idx++;
            @(negedge clk);
            budget++;
        end
        checkOutput("load_timeout", 32'(idx), 32'(DEPTH + 1));
        checkOutput("busy_before_done", 32'(lastBusy), 32'd1);
        checkOutput("done_before_done", 32'(lastDone), 32'd0);
        checkOutput("res_done", 32'(done), 32'd1);
        checkOutput("res_busy", 32'(busy), 32'd0);
        checkOutput("res_ready", 32'(in_ready), 32'd0);
        checkOutput("res_ok", 32'(ok), 32'(expOk));
        checkOutput("res_err", 32'(err), 32'(!expOk));
        if (gapPct == 0) checkOutput("done_latency", 32'(edgeCnt - sEdge), 32'(DEPTH + 1));
        #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = $urandom_range(255);
        @(negedge clk);
        checkOutput("hold_done", 32'(done), 32'd1);
        checkOutput("hold_ok", 32'(ok), 32'(expOk));
        checkOutput("hold_busy", 32'(busy), 32'd0);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("strobe_count", 32'(wrAddrQ.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < wrAddrQ.size(); i++) begin
            checkOutput("strobe_addr", 32'(wrAddrQ[i]), 32'(i));
            checkOutput("strobe_data", 32'(wrDataQ[i]), 32'(ldData[i]));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        #1;
        rst      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("idle_ready", 32'(in_ready), 32'd0);
        checkOutput("idle_no_we", 32'(mem_we), 32'd0);
        #1;
        in_valid = 1'b0;

        $display("[TB] gapless counting load, good checksum");
        for (int i = 0; i < DEPTH; i++) ldData[i] = 8'(i);
        applyStimulus(0, -1, 1'b0, 8'hE0);

        $display("[TB] same data, bad checksum");
        applyStimulus(0, -1, 1'b0, 8'h00);

        $display("[TB] all-ones data with random gaps");
        for (int i = 0; i < DEPTH; i++) ldData[i] = 8'hFF;
        applyStimulus(40, -1, 1'b0, 8'hC0);

        $display("[TB] start pulsed mid-load and during checksum");
        for (int i = 0; i < DEPTH; i++) ldData[i] = 8'($urandom_range(255));
        applyStimulus(20, 20, 1'b1, modelSum());

        $display("[TB] reset in the middle of a load");
        @(negedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = ldData[i];
            @(negedge clk);
            #1;
        end
        rst     = 1'b1;
        in_data = ldData[10];
        @(negedge clk);
        checkAllZero("midreset");
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) ldData[i] = 8'($urandom_range(255));
        applyStimulus(0, -1, 1'b0, modelSum());

        $display("[TB] random loads");
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < DEPTH; i++) ldData[i] = 8'($urandom_range(255));
            applyStimulus(int'($urandom_range(50)), -1, 1'b0,
                          ($urandom_range(1) == 1) ? modelSum() : 8'($urandom_range(255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
